// File: rtl/dsp_timing.sv
// Display timing front end: pixel strobe, beam counters, sync/visible decode,
// blink phase and character-cell / glyph coordinate decode.
module dsp_timing #(
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter int CLK_DIV      = 2,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixclk,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic       blink,
  output logic [6:0] char_col,
  output logic [4:0] char_row,
  output logic [2:0] pix_x,
  output logic [3:0] pix_y
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);
  localparam int FR_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_VIS_L  = 10'(H_VIS);
  localparam logic [9:0]       V_VIS_L  = 10'(V_VIS);
  localparam logic [9:0]       HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0]       HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]       VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0]       VS_END   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

  logic [DIV_W-1:0] div;
  logic [9:0]       h;
  logic [9:0]       v;
  logic [FR_W-1:0]  frame;
  logic             line_end_p0;
  logic             frame_end_p0;
  logic             hs_act_p0;
  logic             vs_act_p0;
  logic             vis_p0;

  function automatic logic in_range(input logic [9:0] x,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (x >= lo) && (x < hi);
  endfunction

  // Stage p0: decode of the current (pre-increment) beam position
  assign line_end_p0  = (h == H_LAST);
  assign frame_end_p0 = line_end_p0 && (v == V_LAST);
  assign hs_act_p0    = in_range(h, HS_START, HS_END);
  assign vs_act_p0    = in_range(v, VS_START, VS_END);
  assign vis_p0       = (h < H_VIS_L) && (v < V_VIS_L);

  // Strobe is registered so it is a clean single-clk pulse one cycle after the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      pixclk <= 1'b0;
    end else begin
      pixclk <= (div == DIV_LAST);
      div    <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h     <= '0;
      v     <= '0;
      frame <= '0;
      blink <= 1'b0;
    end else if (pixclk) begin
      h <= line_end_p0 ? '0 : h + 1'b1;
      if (line_end_p0)
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      if (frame_end_p0) begin
        if (frame == FR_LAST) begin
          frame <= '0;
          blink <= ~blink;
        end else begin
          frame <= frame + 1'b1;
        end
      end
    end
  end

  // Stage p1: registered outputs, one pixel behind the counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      blank    <= 1'b0;
      char_col <= '0;
      char_row <= '0;
      pix_x    <= '0;
      pix_y    <= '0;
    end else if (pixclk) begin
      hsync    <= ~hs_act_p0;
      vsync    <= ~vs_act_p0;
      blank    <= vis_p0;
      char_col <= h[9:3];
      char_row <= v[8:4];
      pix_x    <= h[2:0];
      pix_y    <= v[3:0];
    end
  end

endmodule

// File: tb/tb_dsp_timing.sv
// Directed bench for dsp_timing: reset, line/frame timing, cell decode,
// blink cadence and mid-frame asynchronous reset.
module tb_dsp_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
  logic       pixclk_a, hsync_a, vsync_a, blank_a, blink_a;
  logic       pixclk_b, hsync_b, vsync_b, blank_b, blink_b;
  logic       pixclk_c, hsync_c, vsync_c, blank_c, blink_c;
  logic [6:0] char_col_a, char_col_b, char_col_c;
  logic [4:0] char_row_a, char_row_b, char_row_c;
  logic [2:0] pix_x_a, pix_x_b, pix_x_c;
  logic [3:0] pix_y_a, pix_y_b, pix_y_c;

  // Default 640x480 geometry
  dsp_timing u_a (
    .clk(clk), .rst(rst_a), .pixclk(pixclk_a), .hsync(hsync_a), .vsync(vsync_a),
    .blank(blank_a), .blink(blink_a), .char_col(char_col_a), .char_row(char_row_a),
    .pix_x(pix_x_a), .pix_y(pix_y_a)
  );

  // Tiny frame (8x5 = 40 strobes) for blink cadence
  dsp_timing #(
    .H_VIS(4), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_VIS(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(2), .BLINK_FRAMES(2)
  ) u_b (
    .clk(clk), .rst(rst_b), .pixclk(pixclk_b), .hsync(hsync_b), .vsync(vsync_b),
    .blank(blank_b), .blink(blink_b), .char_col(char_col_b), .char_row(char_row_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b)
  );

  // Short 12-pixel lines with default vertical timing (525 lines)
  dsp_timing #(
    .H_VIS(8), .H_FP(1), .H_SYNC(1), .H_BP(2)
  ) u_c (
    .clk(clk), .rst(rst_c), .pixclk(pixclk_c), .hsync(hsync_c), .vsync(vsync_c),
    .blank(blank_c), .blink(blink_c), .char_col(char_col_c), .char_row(char_row_c),
    .pix_x(pix_x_c), .pix_y(pix_y_c)
  );

  task automatic test_reset();
    logic [5:0] pc;
    rst_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({pixclk_a, hsync_a, vsync_a, blank_a, blink_a} !== 5'b01100 ||
          {char_col_a, char_row_a, pix_x_a, pix_y_a} !== 19'd0) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: ctl=%b cells=%h, required ctl=01100 cells=0",
                 i, {pixclk_a, hsync_a, vsync_a, blank_a, blink_a},
                 {char_col_a, char_row_a, pix_x_a, pix_y_a});
      end
    end
    rst_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pc[i] = pixclk_a;
    end
    checks++;
    if (pc !== 6'b101010) begin
      failures++;
      $display("FAIL reset_release_pixclk: pattern=%b, required 101010", pc);
    end
  endtask

  task automatic test_line();
    int hs_low = 0, hs_first = 0, hs_last = 0, bl_high = 0, bl_first_low = 0;
    int vs_low = 0, pc_bad = 0;
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 801; k++) begin
      @(negedge clk);
      if (pixclk_a !== 1'b1) pc_bad++;
      @(negedge clk);
      if (pixclk_a !== 1'b0) pc_bad++;
      if (k <= 800) begin
        if (hsync_a === 1'b0) begin
          hs_low++;
          if (hs_first == 0) hs_first = k;
          hs_last = k;
        end
        if (vsync_a !== 1'b1) vs_low++;
        if (blank_a === 1'b1) bl_high++;
        else if (bl_first_low == 0) bl_first_low = k;
      end
      if (k == 524) begin
        checks++;
        if (char_col_a !== 7'd65 || pix_x_a !== 3'd3 || char_row_a !== 5'd0 ||
            pix_y_a !== 4'd0 || blank_a !== 1'b1) begin
          failures++;
          $display("FAIL cell_h523: col=%0d px=%0d row=%0d py=%0d blank=%b, required 65 3 0 0 1",
                   char_col_a, pix_x_a, char_row_a, pix_y_a, blank_a);
        end
      end
      if (k == 800) begin
        checks++;
        if (char_col_a !== 7'd99 || pix_x_a !== 3'd7 || pix_y_a !== 4'd0) begin
          failures++;
          $display("FAIL line_last_pixel: col=%0d px=%0d py=%0d, required 99 7 0",
                   char_col_a, pix_x_a, pix_y_a);
        end
      end
      if (k == 801) begin
        checks++;
        if (char_col_a !== 7'd0 || pix_x_a !== 3'd0 || pix_y_a !== 4'd1 || blank_a !== 1'b1) begin
          failures++;
          $display("FAIL line_wrap: col=%0d px=%0d py=%0d blank=%b, required 0 0 1 1",
                   char_col_a, pix_x_a, pix_y_a, blank_a);
        end
      end
    end
    checks++;
    if (hs_low !== 96 || hs_first !== 657 || hs_last !== 752) begin
      failures++;
      $display("FAIL hsync_window: low=%0d first=%0d last=%0d, required 96 657 752",
               hs_low, hs_first, hs_last);
    end
    checks++;
    if (bl_high !== 640 || bl_first_low !== 641) begin
      failures++;
      $display("FAIL line_blank: high=%0d first_low=%0d, required 640 641", bl_high, bl_first_low);
    end
    checks++;
    if (vs_low !== 0) begin
      failures++;
      $display("FAIL line0_vsync: low strobes=%0d, required 0", vs_low);
    end
    checks++;
    if (pc_bad !== 0) begin
      failures++;
      $display("FAIL pixclk_cadence: bad samples=%0d, required 0", pc_bad);
    end
  endtask

  task automatic test_frame();
    int vs_low = 0, vs_first = -1, vs_last = -1, bl_high = 0, bl_late = 0, hs_low = 0;
    int line;
    rst_c = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 6301; k++) begin
      repeat (2) @(negedge clk);
      line = (k - 1) / 12;
      if (k <= 6300) begin
        if (vsync_c === 1'b0) begin
          vs_low++;
          if (vs_first < 0) vs_first = line;
          vs_last = line;
        end
        if (hsync_c === 1'b0) hs_low++;
        if (blank_c === 1'b1) begin
          bl_high++;
          if (line >= 480) bl_late++;
        end
      end
      if (k == 450) begin
        checks++;
        if (char_row_c !== 5'd2 || pix_y_c !== 4'd5 || pix_x_c !== 3'd5 ||
            char_col_c !== 7'd0 || blank_c !== 1'b1) begin
          failures++;
          $display("FAIL cell_v37: row=%0d py=%0d px=%0d col=%0d blank=%b, required 2 5 5 0 1",
                   char_row_c, pix_y_c, pix_x_c, char_col_c, blank_c);
        end
      end
      if (k == 6300) begin
        checks++;
        if (pix_y_c !== 4'd12 || char_row_c !== 5'd0 || blank_c !== 1'b0) begin
          failures++;
          $display("FAIL frame_last_line: py=%0d row=%0d blank=%b, required 12 0 0",
                   pix_y_c, char_row_c, blank_c);
        end
      end
      if (k == 6301) begin
        checks++;
        if (pix_y_c !== 4'd0 || char_row_c !== 5'd0 || pix_x_c !== 3'd0 || blank_c !== 1'b1) begin
          failures++;
          $display("FAIL frame_wrap: py=%0d row=%0d px=%0d blank=%b, required 0 0 0 1",
                   pix_y_c, char_row_c, pix_x_c, blank_c);
        end
      end
    end
    checks++;
    if (vs_low !== 24 || vs_first !== 490 || vs_last !== 491) begin
      failures++;
      $display("FAIL vsync_window: low=%0d first_line=%0d last_line=%0d, required 24 490 491",
               vs_low, vs_first, vs_last);
    end
    checks++;
    if (bl_high !== 3840 || bl_late !== 0) begin
      failures++;
      $display("FAIL frame_blank: high=%0d late=%0d, required 3840 0", bl_high, bl_late);
    end
    checks++;
    if (hs_low !== 525) begin
      failures++;
      $display("FAIL lines_per_frame: hsync pulses=%0d, required 525", hs_low);
    end
  endtask

  task automatic test_blink();
    logic prev = 1'b0;
    int toggles = 0, tog1 = 0, tog2 = 0;
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 161; k++) begin
      repeat (2) @(negedge clk);
      if (blink_b !== prev) begin
        toggles++;
        if (toggles == 1) tog1 = k;
        if (toggles == 2) tog2 = k;
        prev = blink_b;
      end
      if (k == 80) begin
        checks++;
        if (blank_b !== 1'b0 || blink_b !== 1'b1) begin
          failures++;
          $display("FAIL blink_at_wrap: blank=%b blink=%b, required 0 1", blank_b, blink_b);
        end
      end
      if (k == 81) begin
        checks++;
        if (blank_b !== 1'b1 || pix_x_b !== 3'd0 || pix_y_b !== 4'd0) begin
          failures++;
          $display("FAIL blink_after_wrap: blank=%b px=%0d py=%0d, required 1 0 0",
                   blank_b, pix_x_b, pix_y_b);
        end
      end
    end
    checks++;
    if (toggles !== 2 || tog1 !== 80 || tog2 !== 160) begin
      failures++;
      $display("FAIL blink_period: toggles=%0d first=%0d second=%0d, required 2 80 160",
               toggles, tog1, tog2);
    end
  endtask

  task automatic test_mid_reset();
    int hs_low = 0;
    rst_c = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 2406; k++) repeat (2) @(negedge clk);
    checks++;
    if (char_row_c !== 5'd12 || pix_y_c !== 4'd8 || pix_x_c !== 3'd5 || blank_c !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_pos: row=%0d py=%0d px=%0d blank=%b, required 12 8 5 1",
               char_row_c, pix_y_c, pix_x_c, blank_c);
    end
    #2 rst_c = 1'b1;
    #1;
    checks++;
    if ({pixclk_c, hsync_c, vsync_c, blank_c, blink_c} !== 5'b01100 ||
        {char_col_c, char_row_c, pix_x_c, pix_y_c} !== 19'd0) begin
      failures++;
      $display("FAIL async_reset: ctl=%b cells=%h, required ctl=01100 cells=0",
               {pixclk_c, hsync_c, vsync_c, blank_c, blink_c},
               {char_col_c, char_row_c, pix_x_c, pix_y_c});
    end
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 6301; k++) begin
      repeat (2) @(negedge clk);
      if (k <= 6300 && hsync_c === 1'b0) hs_low++;
      if (k == 1) begin
        checks++;
        if ({char_col_c, char_row_c, pix_x_c, pix_y_c} !== 19'd0 || blank_c !== 1'b1) begin
          failures++;
          $display("FAIL restart_origin: cells=%h blank=%b, required 0 1",
                   {char_col_c, char_row_c, pix_x_c, pix_y_c}, blank_c);
        end
      end
      if (k == 13) begin
        checks++;
        if (pix_y_c !== 4'd1 || pix_x_c !== 3'd0) begin
          failures++;
          $display("FAIL restart_line1: py=%0d px=%0d, required 1 0", pix_y_c, pix_x_c);
        end
      end
      if (k == 6301) begin
        checks++;
        if (pix_y_c !== 4'd0 || char_row_c !== 5'd0 || blank_c !== 1'b1) begin
          failures++;
          $display("FAIL restart_frame_wrap: py=%0d row=%0d blank=%b, required 0 0 1",
                   pix_y_c, char_row_c, blank_c);
        end
      end
    end
    checks++;
    if (hs_low !== 525) begin
      failures++;
      $display("FAIL restart_lines: hsync pulses=%0d, required 525", hs_low);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_blink();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
